// File: rtl/rv32i_trap_pkg.sv
// Shared types and constants for the RV32I machine-mode trap sequencer.
package rv32i_trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_TRAP     = 3'd2,
    ST_MRET     = 3'd3,
    ST_REDIRECT = 3'd4
  } trap_state_e;

  localparam logic [3:0] IRQ_MEI_CODE        = 4'd11;
  localparam logic [3:0] IRQ_MTI_CODE        = 4'd7;
  localparam int         MSTATUS_MIE_BIT     = 3;
  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/rv32i_irq_prio.sv
// Machine interrupt pending/priority decode: MEI wins over MTI, gated by mstatus.MIE.
module rv32i_irq_prio
  import rv32i_trap_pkg::*;
(
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  input  logic [31:0] mip,
  output logic        irq_pend,
  output logic [3:0]  irq_code
);

  logic [31:0] w_act;
  logic        w_mei;
  logic        w_mti;
  logic        w_unused;

  assign w_act    = mie & mip;
  assign w_mei    = w_act[IRQ_MEI_CODE];
  assign w_mti    = w_act[IRQ_MTI_CODE];
  assign irq_pend = mstatus[MSTATUS_MIE_BIT] && (w_mei || w_mti);
  assign irq_code = w_mei ? IRQ_MEI_CODE : IRQ_MTI_CODE;

  // Only MIE and the two supported interrupt lines matter here.
  assign w_unused = &{1'b0, mstatus[31:4], mstatus[2:0], w_act[31:12], w_act[10:8], w_act[6:0]};

endmodule

// File: rtl/rv32i_trap_ctrl.sv
// Trap/MRET sequencer between the RV32I pipeline and the M-mode CSR file.
module rv32i_trap_ctrl
  import rv32i_trap_pkg::*;
#(
  parameter logic [31:0] ADDR_MASK   = 32'h00FFFFFF,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic [31:0] irq_pc,
  input  logic        pipe_idle,
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  input  logic [31:0] mip,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        exception_trigger,
  output logic [31:0] exception_cause,
  output logic [31:0] exception_pc,
  output logic [31:0] exception_value,
  output logic        mret_trigger,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  trap_state_e r_state;
  logic [31:0] r_cause;
  logic [31:0] r_pc;
  logic [31:0] r_val;
  logic [31:0] r_redir_pc;

  logic        w_irq_pend;
  logic [3:0]  w_irq_code;
  logic [31:0] w_base;
  logic        w_vec;
  logic [31:0] w_trap_tgt;

  rv32i_irq_prio u_prio (
    .mstatus  (mstatus),
    .mie      (mie),
    .mip      (mip),
    .irq_pend (w_irq_pend),
    .irq_code (w_irq_code)
  );

  // Vectoring applies only to interrupts; cause[31] marks an interrupt capture.
  assign w_base     = mtvec & ~32'h3;
  assign w_vec      = VECTORED_EN && (mtvec[1:0] == MTVEC_MODE_VECTORED) && r_cause[31];
  assign w_trap_tgt = (w_vec ? (w_base + {26'b0, r_cause[3:0], 2'b00}) : w_base) & ADDR_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cause    <= '0;
      r_pc       <= '0;
      r_val      <= '0;
      r_redir_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (exc_valid) begin
            r_cause <= {28'b0, exc_cause};
            r_pc    <= exc_pc & ADDR_MASK;
            r_val   <= exc_tval;
            r_state <= ST_TRAP;
          end else if (mret_valid) begin
            r_state <= ST_MRET;
          end else if (w_irq_pend) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (exc_valid) begin
            r_cause <= {28'b0, exc_cause};
            r_pc    <= exc_pc & ADDR_MASK;
            r_val   <= exc_tval;
            r_state <= ST_TRAP;
          end else if (pipe_idle) begin
            if (w_irq_pend) begin
              r_cause <= {1'b1, 27'b0, w_irq_code};
              r_pc    <= irq_pc & ADDR_MASK;
              r_val   <= '0;
              r_state <= ST_TRAP;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_TRAP: begin
          r_redir_pc <= w_trap_tgt;
          r_state    <= ST_REDIRECT;
        end
        ST_MRET: begin
          r_redir_pc <= mepc & ADDR_MASK;
          r_state    <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Moore decode: everything below depends only on registered state.
  assign exception_trigger = (r_state == ST_TRAP);
  assign mret_trigger      = (r_state == ST_MRET);
  assign exception_cause   = exception_trigger ? r_cause : '0;
  assign exception_pc      = exception_trigger ? r_pc    : '0;
  assign exception_value   = exception_trigger ? r_val   : '0;
  assign flush             = exception_trigger || mret_trigger;
  assign redirect_valid    = (r_state == ST_REDIRECT);
  assign redirect_pc       = redirect_valid ? r_redir_pc : '0;
  assign stall             = (r_state != ST_IDLE);
  assign busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rv32i_trap_ctrl.sv
// Directed bench for rv32i_trap_ctrl with hand-computed expectations.
module tb_rv32i_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret_valid;
  logic [31:0] irq_pc;
  logic        pipe_idle;
  logic [31:0] mstatus, mie, mip, mtvec, mepc;
  logic        exception_trigger, mret_trigger, stall, flush, redirect_valid, busy;
  logic [31:0] exception_cause, exception_pc, exception_value, redirect_pc;
  logic        redirect_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32i_trap_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .exc_valid         (exc_valid),
    .exc_cause         (exc_cause),
    .exc_pc            (exc_pc),
    .exc_tval          (exc_tval),
    .mret_valid        (mret_valid),
    .irq_pc            (irq_pc),
    .pipe_idle         (pipe_idle),
    .mstatus           (mstatus),
    .mie               (mie),
    .mip               (mip),
    .mtvec             (mtvec),
    .mepc              (mepc),
    .exception_trigger (exception_trigger),
    .exception_cause   (exception_cause),
    .exception_pc      (exception_pc),
    .exception_value   (exception_value),
    .mret_trigger      (mret_trigger),
    .stall             (stall),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .redirect_ready    (redirect_ready),
    .busy              (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trig"},  {31'b0, exception_trigger}, 32'd0);
    chk({tag, "_mret"},  {31'b0, mret_trigger}, 32'd0);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "_flush"}, {31'b0, flush}, 32'd0);
    chk({tag, "_rv"},    {31'b0, redirect_valid}, 32'd0);
    chk({tag, "_rpc"},   redirect_pc, 32'd0);
    chk({tag, "_cause"}, exception_cause, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    mret_valid = 1'b0; irq_pc = '0; pipe_idle = 1'b0; mstatus = '0; mie = '0;
    mip = '0; mtvec = '0; mepc = '0; redirect_ready = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Synchronous exception, direct mtvec
    mtvec = 32'h800; redirect_ready = 1'b1;
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    tick();
    exc_valid = 1'b0;
    chk("exc_trig",  {31'b0, exception_trigger}, 32'd1);
    chk("exc_cause", exception_cause, 32'h2);
    chk("exc_pc",    exception_pc, 32'h100);
    chk("exc_val",   exception_value, 32'hDEAD);
    chk("exc_flush", {31'b0, flush}, 32'd1);
    tick();
    chk("exc_rv",    {31'b0, redirect_valid}, 32'd1);
    chk("exc_rpc",   redirect_pc, 32'h800);
    chk("exc_trig0", {31'b0, exception_trigger}, 32'd0);
    tick();
    chk("exc_busy0", {31'b0, busy}, 32'd0);

    // Vectored timer interrupt with a 3-cycle drain
    mtvec = 32'h801; mstatus = 32'h8; mie = 32'h80; mip = 32'h80;
    irq_pc = 32'h200; pipe_idle = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mti_stall", {31'b0, stall}, 32'd1);
      chk("mti_notrig", {31'b0, exception_trigger}, 32'd0);
    end
    pipe_idle = 1'b1;
    tick();
    mip = '0;
    chk("mti_trig",  {31'b0, exception_trigger}, 32'd1);
    chk("mti_cause", exception_cause, 32'h80000007);
    chk("mti_pc",    exception_pc, 32'h200);
    chk("mti_val",   exception_value, 32'h0);
    tick();
    chk("mti_rpc",   redirect_pc, 32'h81C);
    tick();
    chk("mti_busy0", {31'b0, busy}, 32'd0);

    // MEI and MTI together: MEI wins
    mie = 32'h880; mip = 32'h880;
    tick();
    chk("mei_drain", {31'b0, stall}, 32'd1);
    tick();
    mip = '0;
    chk("mei_trig",  {31'b0, exception_trigger}, 32'd1);
    chk("mei_cause", exception_cause, 32'h8000000B);
    tick();
    chk("mei_rpc",   redirect_pc, 32'h82C);
    tick();
    chk("mei_busy0", {31'b0, busy}, 32'd0);

    // Interrupt withdrawn during drain
    pipe_idle = 1'b0; mie = 32'h80; mip = 32'h80;
    tick();
    chk("wd_busy", {31'b0, busy}, 32'd1);
    mip = '0;
    tick();
    chk("wd_flush", {31'b0, flush}, 32'd0);
    pipe_idle = 1'b1;
    tick();
    chk("wd_busy0", {31'b0, busy}, 32'd0);
    chk("wd_trig0", {31'b0, exception_trigger}, 32'd0);
    chk("wd_flush0", {31'b0, flush}, 32'd0);

    // MRET with redirect held off by fetch
    mepc = 32'h12345678; redirect_ready = 1'b0; mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    chk("mret_trig",  {31'b0, mret_trigger}, 32'd1);
    chk("mret_flush", {31'b0, flush}, 32'd1);
    chk("mret_etrig", {31'b0, exception_trigger}, 32'd0);
    tick();
    chk("mret_trig0", {31'b0, mret_trigger}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("mret_rv",  {31'b0, redirect_valid}, 32'd1);
      chk("mret_rpc", redirect_pc, 32'h00345678);
      tick();
    end
    redirect_ready = 1'b1;
    tick();
    chk("mret_busy0", {31'b0, busy}, 32'd0);

    // Exception preempts a draining interrupt
    pipe_idle = 1'b0; mip = 32'h80;
    tick();
    chk("pre_drain", {31'b0, busy}, 32'd1);
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'hAB000300; exc_tval = 32'h44;
    tick();
    exc_valid = 1'b0; mip = '0; redirect_ready = 1'b0;
    chk("pre_cause", exception_cause, 32'h5);
    chk("pre_pc",    exception_pc, 32'h300);
    chk("pre_val",   exception_value, 32'h44);
    tick();
    chk("pre_rpc",   redirect_pc, 32'h800);

    // Reset in REDIRECT
    rst_n = 1'b0;
    tick();
    chk_all_zero("rstmid");
    rst_n = 1'b1;
    tick();
    chk_all_zero("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
